// File: rtl/mem_access_unit.sv
// Load/store front-end for the program/data RAM.
// Takes one CPU request at a time, performs byte/half/word loads with
// sign or zero extension, and builds sub-word stores by read-modify-write.
// Misaligned or illegal-size requests are answered with an error and never reach the RAM.

`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

module mem_access_unit #(
  parameter int ADDR_WIDTH = `RAM_ADDRESS_BITWIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_write_data,
  input  logic [31:0]           ram_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state, state_nxt;

  logic        accept;
  logic        req_err;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_ready  = (state == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == S_RESP);
  assign resp_error = (state == S_RESP) && err_q;
  assign ram_wren   = (state == S_WRITE);

  // Classify the incoming request as illegal size or misaligned.
  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  // Lane selection and extension of the word returned by the RAM.
  always_comb begin
    byte_v   = ram_data[{lane_q, 3'b000} +: 8];
    half_v   = ram_data[{lane_q[1], 4'b0000} +: 16];
    load_val = ram_data;
    unique case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{signed_q & half_v[15]}}, half_v};
      default: load_val = ram_data;
    endcase
  end

  // Sub-word store merge: only the addressed lane is replaced.
  always_comb begin
    merged = ram_data;
    if (size_q == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_nxt = S_RESP;
          end else if (req_we && (req_size == 2'b10)) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_READ;
          end
        end
      end
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = we_q ? S_WRITE : S_RESP;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, RAM address/data and load result registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      we_q           <= 1'b0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      lane_q         <= '0;
      wdata_q        <= '0;
      err_q          <= 1'b0;
      resp_rdata     <= '0;
      ram_address    <= '0;
      ram_write_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            size_q     <= req_size;
            signed_q   <= req_signed;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata;
            err_q      <= req_err;
            resp_rdata <= '0;
            // The address is only driven for legal requests, so an error leaves the RAM port untouched.
            if (!req_err) begin
              ram_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (req_we && (req_size == 2'b10)) begin
                ram_write_data <= req_wdata;
              end
            end
          end
        end
        S_WAIT: begin
          if (we_q) begin
            ram_write_data <= merged;
          end else begin
            resp_rdata <= load_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a one-cycle-latency RAM model.
module tb_mem_access_unit;

  localparam int AW = 8;

  logic          clk;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_write_data;
  logic [31:0]   ram_data;

  logic [31:0]   mem [0:63];
  logic          bd_we;
  logic [5:0]    bd_idx;
  logic [31:0]   bd_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wlat;
    int          acc;
  } exp_t;

  exp_t exq[$];

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int wren_cnt = 0;
  int wren_at = 0;
  bit ready_chk = 0;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .ram_wren       (ram_wren),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_data       (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, whole-word write, plus a backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (ram_wren) begin
      mem[ram_address[7:2]] <= ram_write_data;
    end
    ram_data <= mem[ram_address[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on each resp_valid.
  always @(negedge clk) begin
    if (ready_chk) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, exq.size() == 0});
    end
    if (ram_wren) begin
      if (exq.size() == 0) begin
        check("unexpected ram_wren", 32'd1, 32'd0);
      end else begin
        wren_cnt++;
        wren_at = cyc - exq[0].acc + 1;
      end
      check("ram_address aligned", {30'd0, ram_address[1:0]}, 32'd0);
    end
    if (resp_valid) begin
      if (exq.size() == 0) begin
        check("unexpected resp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exq.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        check("wren count", 32'(wren_cnt), (e.wlat != 0) ? 32'd1 : 32'd0);
        if (e.wlat != 0) check("wren cycle", 32'(wren_at), 32'(e.wlat));
      end
      wren_cnt = 0;
      wren_at  = 0;
    end
  end

  task automatic poke(input logic [5:0] idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Drive a request and leave req_valid high; push its expectation at the accept edge.
  task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [7:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input int lat,
                      input int wlat, output int acc);
    exp_t e;
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        e.rdata = er; e.err = ee; e.lat = lat; e.wlat = wlat; e.acc = acc;
        exq.push_back(e);
        return;
      end
      @(posedge clk); #1;
    end
    check("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exq.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("response timeout", 32'(exq.size()), 32'd0);
    exq.delete();
  endtask

  initial begin
    int a1, a2;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_error", {31'd0, resp_error}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst ram_wren", {31'd0, ram_wren}, 32'd0);
    check("rst ram_address", {24'd0, ram_address}, 32'd0);
    check("rst ram_write_data", ram_write_data, 32'd0);
    poke(6'h04, 32'h8899AABB);
    rstn = 1'b1;
    @(posedge clk); #1;
    ready_chk = 1;

    // Loads
    send(1'b0, 2'b00, 1'b1, 8'h13, 32'h0, 32'hFFFFFF88, 1'b0, 3, 0, a1); drain();
    send(1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 32'h00000088, 1'b0, 3, 0, a1); drain();
    send(1'b0, 2'b01, 1'b1, 8'h10, 32'h0, 32'hFFFFAABB, 1'b0, 3, 0, a1); drain();
    send(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 32'h00008899, 1'b0, 3, 0, a1); drain();
    send(1'b0, 2'b00, 1'b1, 8'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 3, 0, a1); drain();

    // Sub-word stores
    send(1'b1, 2'b01, 1'b0, 8'h12, 32'hFFFF1234, 32'h0, 1'b0, 4, 3, a1); drain();
    check("half store mem", mem[4], 32'h1234AABB);
    poke(6'h04, 32'h8899AABB);
    send(1'b1, 2'b00, 1'b0, 8'h11, 32'hFFFFFF5A, 32'h0, 1'b0, 4, 3, a1); drain();
    check("byte store mem", mem[4], 32'h88995ABB);

    // Word store followed by a load with req_valid held throughout
    send(1'b1, 2'b10, 1'b0, 8'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, a1);
    send(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, a2);
    drain();
    check("back-to-back accept gap", 32'(a2 - a1), 32'd3);
    check("word store mem", mem[8], 32'hDEADBEEF);

    // Errors
    send(1'b0, 2'b10, 1'b0, 8'h22, 32'h0, 32'h0, 1'b1, 1, 0, a1); drain();
    send(1'b0, 2'b01, 1'b0, 8'h11, 32'h0, 32'h0, 1'b1, 1, 0, a1); drain();
    send(1'b0, 2'b11, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1, 1, 0, a1); drain();
    send(1'b1, 2'b10, 1'b0, 8'h21, 32'h11111111, 32'h0, 1'b1, 1, 0, a1); drain();
    check("error store mem", mem[8], 32'hDEADBEEF);

    // Reset while a byte store sits in WAIT
    poke(6'h04, 32'h8899AABB);
    send(1'b1, 2'b00, 1'b0, 8'h11, 32'h0000005A, 32'h0, 1'b0, 4, 3, a1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    ready_chk = 0;
    exq.delete();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("ready after reset", {31'd0, req_ready}, 32'd1);
    ready_chk = 1;
    repeat (6) @(posedge clk);
    #1;
    check("mem after reset abort", mem[4], 32'h8899AABB);

    // Unit still works after the abort
    send(1'b0, 2'b00, 1'b0, 8'h11, 32'h0, 32'h000000AA, 1'b0, 3, 0, a1); drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
